bictr_sweep_ctrl: RTL

Sweep controller that drives the load/cen/up_dn/data/count_to interface of the dynamic count-to up/down counter (DW03_bictr_dcnto) and consumes its tercnt flag. On a start request it presets the counter to a low bound, then counts up to a high bound. In ping-pong mode it then reverses direction, repeating for a programmed number of half-sweeps, and pulses done at the end. It sits between the register/control layer and the counter instance.

---
 rtl/bictr_pkg.sv | 15 +
 rtl/bictr_sweep_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bictr_pkg.sv
// bictr_pkg
// Shared constants for the bictr sweep controller: controller state encoding
// and sweep mode selectors.
package bictr_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;  // waiting for start
  localparam logic [2:0] ST_LOAD = 3'd1;  // presetting counter to lo
  localparam logic [2:0] ST_UP   = 3'd2;  // counting up toward hi
  localparam logic [2:0] ST_DOWN = 3'd3;  // counting down toward lo
  localparam logic [2:0] ST_DONE = 3'd4;  // one-cycle completion pulse

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

endpackage

// File: rtl/bictr_sweep_ctrl.sv
// bictr_sweep_ctrl
// Drives the load/cen/up_dn/data/count_to interface of a dynamic count-to
// up/down counter. A start presets the counter to lo, then sweeps up to hi;
// in ping-pong mode the direction reverses for a programmed number of
// half-sweeps before a single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; bounds and count_to held
// LOAD  | counter preset to latched lo (load low for one cycle)
// UP    | counting toward hi; cen drops on terminal count
// DOWN  | counting toward lo; cen drops on terminal count
// DONE  | done pulse, counter idle, back to IDLE
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_abort      start request (IDLE only), synchronous abort
//   i_mode                0 single up-sweep, 1 ping-pong
//   i_lo, i_hi            unsigned sweep bounds
//   i_nsweep              half-sweeps in ping-pong mode (0 acts as 1)
//   i_tercnt              counter terminal-count flag (count == count_to)
//   o_load                counter preset, active-low
//   o_cen, o_up_dn        counter enable and direction
//   o_data, o_count_to    preset value and current target
//   o_busy, o_done, o_err status; done/err are single-cycle pulses
//   o_sweeps              completed half-sweeps
module bictr_sweep_ctrl
  import bictr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NSW_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [NSW_W-1:0] i_nsweep,
  input  logic             i_tercnt,
  output logic             o_load,
  output logic             o_cen,
  output logic             o_up_dn,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_count_to,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [NSW_W-1:0] o_sweeps
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_mode;
  logic [NSW_W-1:0] r_nsw;
  logic [NSW_W-1:0] r_sweeps;
  logic             r_err;

  logic             w_idle;
  logic             w_bounds_ok;
  logic [NSW_W-1:0] w_sw_inc;
  logic [NSW_W-1:0] w_nsw_eff;
  logic             w_last;
  logic             w_sweeping;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_bounds_ok = (i_lo < i_hi);
  assign w_sweeping  = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_sw_inc    = r_sweeps + {{(NSW_W-1){1'b0}}, 1'b1};
  assign w_nsw_eff   = (r_nsw == '0) ? {{(NSW_W-1){1'b0}}, 1'b1} : r_nsw;
  // Terminate after this half-sweep if single mode or the count is reached.
  assign w_last      = (r_mode == MODE_SINGLE) || (w_sw_inc >= w_nsw_eff);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start && w_bounds_ok) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_UP;
      ST_UP:   if (i_tercnt) w_next = w_last ? ST_DONE : ST_DOWN;
      ST_DOWN: if (i_tercnt) w_next = w_last ? ST_DONE : ST_UP;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (!w_idle && i_abort) w_next = ST_IDLE;
  end

  // Latched bounds, sweep counter and reject flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_mode   <= MODE_SINGLE;
      r_nsw    <= '0;
      r_sweeps <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_idle && i_start && !w_bounds_ok;
      if (w_idle && i_start) begin
        // Bounds are latched even on a rejected start so data reflects them.
        r_lo     <= i_lo;
        r_hi     <= i_hi;
        r_mode   <= i_mode;
        r_nsw    <= i_nsweep;
        r_sweeps <= '0;
      end else if (w_sweeping && i_tercnt && !i_abort) begin
        r_sweeps <= w_sw_inc;
      end
    end
  end

  // Output decode
  always_comb begin
    o_load  = 1'b1;
    o_cen   = 1'b0;
    o_up_dn = 1'b1;
    o_done  = 1'b0;
    case (r_state)
      ST_LOAD: o_load = 1'b0;
      // cen gated by tercnt so the counter never steps past a bound.
      ST_UP:   o_cen = !i_tercnt;
      ST_DOWN: begin
        o_up_dn = 1'b0;
        o_cen   = !i_tercnt;
      end
      ST_DONE: o_done = !i_abort;
      default: ;
    endcase
  end

  assign o_data     = r_lo;
  assign o_count_to = (r_state == ST_DOWN) ? r_lo : r_hi;
  assign o_busy     = !w_idle;
  assign o_err      = r_err;
  assign o_sweeps   = r_sweeps;

endmodule
